seven_segment_scan: RTL and testbench

Parametrised, time-multiplexed hex display driver for the board's common-anode seven-segment bank. It extends the team's single-digit hex-to-segment decode with several features:
- digit scanning across `DIGITS` positions;
- a refresh divider;
- a tear-free shadow load of the displayed value;
- per-digit blanking and optional leading-zero suppression.

It sits between the game/score logic, which supplies a packed hex value, and the display pins.

---
 rtl/seven_segment_scan_if.sv | 21 ++
 rtl/seven_segment_scan.sv | 120 ++++++++++++
 tb/tb_seven_segment_scan.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_if.sv
// Bus between the score logic (master) and the seven-segment scan driver (slave).
interface seven_segment_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   blank_mask;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_start;

  modport master (
    output value, load, blank_mask,
    input  seg, an, frame_start
  );

  modport slave (
    input  value, load, blank_mask,
    output seg, an, frame_start
  );
endinterface

// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode hex display driver with a tear-free shadow load,
// per-digit blanking and optional leading-zero suppression.
module seven_segment_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_segment_scan_if.slave  bus
);
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = 4 * DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  disp_q, disp_d;
  logic [VAL_W-1:0]  pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic              wrap_q;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_start_q;

  logic       tc, boundary;
  logic [3:0] cur_nib;
  logic       cur_blank, cur_lz, zero_run, dark;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = 7'b0000001;
      4'h1: seg_code = 7'b1001111;
      4'h2: seg_code = 7'b0010010;
      4'h3: seg_code = 7'b0000110;
      4'h4: seg_code = 7'b1001100;
      4'h5: seg_code = 7'b0100100;
      4'h6: seg_code = 7'b0100000;
      4'h7: seg_code = 7'b0001111;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0000100;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b1100000;
      4'hC: seg_code = 7'b0110001;
      4'hD: seg_code = 7'b1000010;
      4'hE: seg_code = 7'b0110000;
      default: seg_code = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    tc        = (div_cnt_q == DIV_LAST);
    boundary  = tc && (idx_q == IDX_LAST);
    div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A load landing on the boundary goes straight to disp so it is never lost.
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (boundary) begin
      pend_v_d = 1'b0;
      if (bus.load)     disp_d = bus.value;
      else if (pend_v_q) disp_d = pend_q;
    end else if (bus.load) begin
      pend_d   = bus.value;
      pend_v_d = 1'b1;
    end

    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_q[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_blank = bus.blank_mask[k];
        cur_lz    = LZ_BLANK && (k >= 1) && zero_run;
      end
    end
    dark  = cur_blank || cur_lz;
    seg_d = dark ? 7'b1111111 : seg_code(cur_nib);
    an_d  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!dark && (idx_q == IDX_W'(k))) an_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      disp_q        <= '0;
      pend_q        <= '0;
      pend_v_q      <= 1'b0;
      wrap_q        <= 1'b0;
      seg_q         <= 7'b1111111;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      wrap_q        <= boundary;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= wrap_q;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: one DUT with leading-zero suppression, one without,
// both compared every cycle against a frame-arithmetic reference model.
module tb_seven_segment_scan;
  localparam int D = 4;
  localparam int R = 4;
  localparam int F = D * R;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  mask = '0;
  int total = 0;
  int bad = 0;

  // reference model state: cycles since reset, shown and pending values
  int          c = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scan_if #(.DIGITS(D)) bus_lz ();
  seven_segment_scan_if #(.DIGITS(D)) bus_nz ();

  assign bus_lz.value      = value;
  assign bus_lz.load       = load;
  assign bus_lz.blank_mask = mask;
  assign bus_nz.value      = value;
  assign bus_nz.load       = load;
  assign bus_nz.blank_mask = mask;

  seven_segment_scan #(.DIGITS(D), .REFRESH_DIV(R), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .bus(bus_lz.slave)
  );
  seven_segment_scan #(.DIGITS(D), .REFRESH_DIV(R), .LZ_BLANK(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .bus(bus_nz.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t cyc=%0d got=%h exp=%h", tag, $time, c, got, exp);
    end
  endtask

  function automatic void expect_out(input logic [15:0] d, input int idx, input logic [3:0] m,
                                     input bit lz, output logic [6:0] s, output logic [3:0] a);
    logic [15:0] upper;
    logic [3:0]  one;
    int          nib;
    bit          dark;
    upper = d >> (4 * idx);
    nib   = int'(upper & 16'h000F);
    dark  = m[idx] || (lz && idx >= 1 && upper == 16'h0);
    one   = 4'b0001;
    s = dark ? 7'b1111111 : SEG_TAB[nib];
    a = dark ? 4'b1111 : ~(one << idx);
  endfunction

  task automatic tick(input bit r, input bit ld, input logic [15:0] v);
    logic [6:0] es_l, es_n;
    logic [3:0] ea_l, ea_n;
    bit efs;
    int idx;
    rst = r; load = ld; value = v;
    if (r) begin
      es_l = 7'h7F; es_n = 7'h7F; ea_l = 4'hF; ea_n = 4'hF; efs = 1'b0;
      c = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
    end else begin
      idx = (c / R) % D;
      expect_out(m_disp, idx, mask, 1'b1, es_l, ea_l);
      expect_out(m_disp, idx, mask, 1'b0, es_n, ea_n);
      efs = (c >= 1) && (c % F == 0);
      if (c % F == F - 1) begin
        if (ld) m_disp = v;
        else if (m_pv) m_disp = m_pend;
        m_pv = 1'b0;
      end else if (ld) begin
        m_pend = v;
        m_pv = 1'b1;
      end
      c++;
    end
    @(posedge clk);
    #1;
    check("seg_lz", 32'(bus_lz.seg), 32'(es_l));
    check("an_lz", 32'(bus_lz.an), 32'(ea_l));
    check("fs_lz", 32'(bus_lz.frame_start), 32'(efs));
    check("seg_nz", 32'(bus_nz.seg), 32'(es_n));
    check("an_nz", 32'(bus_nz.an), 32'(ea_n));
    check("fs_nz", 32'(bus_nz.frame_start), 32'(efs));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic align(input int pos);
    for (int i = 0; i < F && (c % F) != pos; i++) tick(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset, then free-running scan over several frames
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0);
    idle(3 * F + 2);

    // shadow load mid-frame, visible only after the wrap
    align(5);
    tick(1'b0, 1'b1, 16'h1A3F);
    idle(2 * F);

    // leading zeros
    align(3);
    tick(1'b0, 1'b1, 16'h0050);
    idle(2 * F);

    // last load wins, including a load on the boundary cycle itself
    align(6);
    tick(1'b0, 1'b1, 16'h1111);
    align(F - 1);
    tick(1'b0, 1'b1, 16'h2222);
    idle(F + 4);

    // live blank mask
    tick(1'b0, 1'b1, 16'h8888);
    align(0);
    idle(3);
    mask = 4'b0100;
    idle(F + 5);
    mask = 4'b0000;
    idle(6);

    // reset while a load is pending
    align(4);
    tick(1'b0, 1'b1, 16'h4321);
    idle(3);
    tick(1'b1, 1'b0, 16'h0);
    idle(2 * F + 3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mask = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 29) == 0) mask = 4'h0;
      if ($urandom_range(0, 499) == 0)
        tick(1'b1, $urandom_range(0, 1) == 1, 16'($urandom));
      else if ($urandom_range(0, 11) == 0)
        tick(1'b0, 1'b1, ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom));
      else
        tick(1'b0, 1'b0, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
